// File: rtl/leaf_bft_pkg.sv
// Shared constants, packet field layout and transmit state encoding for the
// leaf-to-BFT interface.
package leaf_bft_pkg;

    localparam int DATA_W      = 32;
    localparam int PKT_W       = 49;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_AW     = 4;
    localparam int CREDIT_W    = 5;
    localparam int CREDIT_INIT = 8;
    localparam int CREDIT_MAX  = 16;

    localparam int VALID_BIT   = 48;
    localparam int LEAF_W      = 5;
    localparam int PORT_LSB    = 39;
    localparam int PORT_W      = 4;
    localparam int SEQ_W       = 7;
    localparam int RET_W       = 8;

    localparam logic [PORT_W-1:0] CREDIT_PORT = 4'hF;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_RUN    = 2'd1,
        TX_REPLAY = 2'd2
    } tx_state_e;

    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [LEAF_W-1:0] leaf,
        input logic [PORT_W-1:0] port,
        input logic [SEQ_W-1:0]  seq,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, leaf, port, seq, data};
    endfunction

endpackage

// File: rtl/leaf_tx_fifo.sv
// Operator-side input buffer. Words become visible to the reader one cycle
// after the write, so a word never leaves the interface sooner than two edges after it arrives.
module leaf_tx_fifo
    import leaf_bft_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   wr_vis_q;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic               wr_ok, rd_ok;

    // Full uses the live write pointer; empty uses the delayed copy.
    assign full_o  = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                     (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
    assign empty_o = (wr_vis_q == rd_ptr_q);

    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            wr_vis_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_vis_q <= wr_ptr_q;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/leaf_interface_tx.sv
// Transmit half of a leaf BFT interface: buffers the operator stream and packs
// words into credit-controlled BFT packets, with single-packet replay.
//
//   state      | meaning
//   TX_IDLE    | ap_start low, nothing sent, FIFO keeps filling
//   TX_RUN     | send one packet per cycle when data and credit are available
//   TX_REPLAY  | re-send the last packet unchanged for one cycle
module leaf_interface_tx
    import leaf_bft_pkg::*;
(
    input  logic                clk_400,
    input  logic                reset_400_n,
    input  logic                ap_start,
    input  logic                resend,
    input  logic [LEAF_W-1:0]   dest_leaf,
    input  logic [PORT_W-1:0]   dest_port,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [PKT_W-1:0]    din_leaf_bft2interface,
    output logic [PKT_W-1:0]    dout_leaf_interface2bft,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err
);

    tx_state_e           state_q, state_d;
    logic [PKT_W-1:0]    dout_q, dout_d;
    logic [PKT_W-1:0]    last_q, last_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                err_q, err_d;
    logic                sent_q, sent_d;

    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                pop, send_new, send_replay;
    logic [RET_W-1:0]    ret;
    logic [9:0]          credit_sum;
    logic                unused_din;

    assign s_ready = reset_400_n && !fifo_full;

    leaf_tx_fifo u_fifo (
        .clk_i     (clk_400),
        .rst_n_i   (reset_400_n),
        .wr_en_i   (s_valid && s_ready),
        .wr_data_i (s_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign ret = (din_leaf_bft2interface[VALID_BIT] &&
                  din_leaf_bft2interface[PORT_LSB +: PORT_W] == CREDIT_PORT)
                 ? din_leaf_bft2interface[RET_W-1:0] : '0;
    assign unused_din = ^{din_leaf_bft2interface[47:43], din_leaf_bft2interface[38:8]};

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        send_new    = 1'b0;
        send_replay = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (ap_start) state_d = TX_RUN;
            end
            TX_RUN: begin
                if (ap_start && resend && sent_q) begin
                    state_d = TX_REPLAY;
                end else begin
                    // A packet launched as ap_start drops still goes out.
                    if (!fifo_empty && credit_q != '0) begin
                        pop      = 1'b1;
                        send_new = 1'b1;
                    end
                    if (!ap_start) state_d = TX_IDLE;
                end
            end
            TX_REPLAY: begin
                send_replay = 1'b1;
                state_d     = TX_RUN;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        dout_d = '0;
        last_d = last_q;
        seq_d  = seq_q;
        sent_d = sent_q;
        err_d  = err_q;
        if (send_new) begin
            dout_d = pack_pkt(dest_leaf, dest_port, seq_q, fifo_rdata);
            last_d = dout_d;
            seq_d  = seq_q + 1'b1;
            sent_d = 1'b1;
        end else if (send_replay) begin
            dout_d = last_q;
        end

        credit_sum = {5'd0, credit_q} + {2'd0, ret} - {9'd0, send_new};
        if (credit_sum > 10'(CREDIT_MAX)) begin
            credit_d = CREDIT_W'(CREDIT_MAX);
            err_d    = 1'b1;
        end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk_400) begin
        if (!reset_400_n) begin
            state_q  <= TX_IDLE;
            dout_q   <= '0;
            last_q   <= '0;
            seq_q    <= '0;
            credit_q <= CREDIT_W'(CREDIT_INIT);
            err_q    <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            last_q   <= last_d;
            seq_q    <= seq_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            sent_q   <= sent_d;
        end
    end

    assign dout_leaf_interface2bft = dout_q;
    assign credit_cnt              = credit_q;
    assign credit_err              = err_q;

endmodule
